adsr_envelope: RTL

Single-voice ADSR (attack/decay/sustain/release) envelope generator. It sits directly downstream of the arpeggiator: each `outN` note-on line drives the `gate` of one instance, four instances per synth. Each instance produces a 16-bit amplitude envelope that the voice mixer multiplies with the oscillator sample. All amplitude updates are paced by a sample-rate `tick` strobe, so envelope times scale with the audio rate, not with `CLK`.

---
 rtl/adsr_envelope.sv | 128 ++++++++++++
 1 files changed

// File: rtl/adsr_envelope.sv
// rtl/adsr_envelope.sv - single-voice ADSR envelope generator paced by a sample tick
// Stage and amplitude advance only on tick cycles; gate edges between ticks are held in retrig_pend.
module adsr_envelope #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             gate,
  input  logic             tick,
  input  logic [WIDTH-1:0] attack_step,
  input  logic [WIDTH-1:0] decay_step,
  input  logic [WIDTH-1:0] sustain_level,
  input  logic [WIDTH-1:0] release_step,
  output logic [WIDTH-1:0] env_out,
  output logic [2:0]       stage,
  output logic             active
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] FULL = {WIDTH{1'b1}};

  state_t st;
  logic   gate_q;
  logic   retrig_pend;
  logic   rise;
  logic   retrig;

  logic        [WIDTH:0]   att_sum;
  logic signed [WIDTH:0]   dec_diff;
  logic        [WIDTH-1:0] rel_diff;

  assign stage  = st;
  assign rise   = gate & ~gate_q;
  assign retrig = retrig_pend | rise;

  // One extra bit keeps the attack sum and decay difference free of wrap.
  assign att_sum  = {1'b0, env_out} + {1'b0, attack_step};
  assign dec_diff = $signed({1'b0, env_out}) - $signed({1'b0, decay_step});
  assign rel_diff = env_out - release_step;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      env_out     <= '0;
      st          <= IDLE;
      active      <= 1'b0;
      gate_q      <= 1'b0;
      retrig_pend <= 1'b0;
    end else begin
      gate_q <= gate;
      if (tick) begin
        retrig_pend <= 1'b0;
        case (st)
          IDLE: begin
            if (gate) begin
              st     <= ATTACK;
              active <= 1'b1;
            end else begin
              env_out <= '0;
              active  <= 1'b0;
            end
          end
          ATTACK: begin
            if (!gate) begin
              st <= RELEASE;
            end else if (att_sum >= {1'b0, FULL} || attack_step == '0) begin
              env_out <= FULL;
              st      <= DECAY;
            end else begin
              env_out <= att_sum[WIDTH-1:0];
            end
            active <= 1'b1;
          end
          DECAY: begin
            if (!gate) begin
              st <= RELEASE;
            end else if (retrig) begin
              st <= ATTACK;
            end else if (dec_diff <= $signed({1'b0, sustain_level}) || decay_step == '0) begin
              env_out <= sustain_level;
              st      <= SUSTAIN;
            end else begin
              env_out <= dec_diff[WIDTH-1:0];
            end
            active <= 1'b1;
          end
          SUSTAIN: begin
            if (!gate) begin
              st <= RELEASE;
            end else if (retrig) begin
              st <= ATTACK;
            end else begin
              env_out <= sustain_level;
            end
            active <= 1'b1;
          end
          RELEASE: begin
            if (gate) begin
              st     <= ATTACK;
              active <= 1'b1;
            end else if (env_out <= release_step || release_step == '0) begin
              env_out <= '0;
              st      <= IDLE;
              active  <= 1'b0;
            end else begin
              env_out <= rel_diff;
              active  <= 1'b1;
            end
          end
          default: begin
            env_out <= '0;
            st      <= IDLE;
            active  <= 1'b0;
          end
        endcase
      end else if (rise) begin
        retrig_pend <= 1'b1;
      end
    end
  end

endmodule
